// File: rtl/ar_arbiter.sv
// Two-master AXI read-address arbiter with round-robin grant and a single
// outstanding burst; watches the R channel to release the grant and flag length mismatches.
//
// state | meaning
// IDLE  | no owner, pick a requester (round-robin on ties)
// ADDR  | owner's AR fields forwarded to the decoder until accepted
// DATA  | AR path closed, counting R beats until RLAST_S
module ar_arbiter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ARVALID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [3:0]        ARLEN_M0,
    output logic              ARREADY_M0,
    input  logic              ARVALID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [3:0]        ARLEN_M1,
    output logic              ARREADY_M1,
    output logic              ARVALID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [ID_W+3:0]   ARID_S,
    output logic [3:0]        ARLEN_S,
    input  logic              ARREADY_S,
    input  logic              RVALID_S,
    input  logic              RREADY_S,
    input  logic              RLAST_S,
    output logic [1:0]        GRANT,
    output logic              LEN_ERR
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state;
    logic [1:0] grant_q;
    logic       last_m1;
    logic [3:0] len_q;
    logic [3:0] beat_cnt;
    logic       len_err_q;

    logic sel_m1;
    logic req_valid;
    logic beat;

    assign sel_m1    = grant_q[1];
    assign req_valid = sel_m1 ? ARVALID_M1 : ARVALID_M0;
    assign beat      = RVALID_S && RREADY_S;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            grant_q   <= 2'b00;
            last_m1   <= 1'b1;
            len_q     <= 4'd0;
            beat_cnt  <= 4'd0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ARVALID_M0 && (!ARVALID_M1 || last_m1)) begin
                        grant_q <= 2'b01;
                        state   <= ADDR;
                    end else if (ARVALID_M1) begin
                        grant_q <= 2'b10;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (req_valid && ARREADY_S) begin
                        len_q    <= sel_m1 ? ARLEN_M1 : ARLEN_M0;
                        beat_cnt <= 4'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt  <= beat_cnt + 4'd1;
                        // RLAST must land exactly on beat number ARLEN
                        len_err_q <= RLAST_S != (beat_cnt == len_q);
                        if (RLAST_S) begin
                            last_m1 <= sel_m1;
                            grant_q <= 2'b00;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is held, even before the edge.
    always_comb begin
        ARVALID_S  = 1'b0;
        ARADDR_S   = '0;
        ARID_S     = '0;
        ARLEN_S    = 4'd0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        GRANT      = 2'b00;
        LEN_ERR    = 1'b0;
        if (ARESETn) begin
            GRANT   = grant_q;
            LEN_ERR = len_err_q;
            if (state == ADDR) begin
                ARVALID_S  = req_valid;
                ARADDR_S   = sel_m1 ? ARADDR_M1 : ARADDR_M0;
                ARID_S     = {3'b000, sel_m1, (sel_m1 ? ARID_M1 : ARID_M0)};
                ARLEN_S    = sel_m1 ? ARLEN_M1 : ARLEN_M0;
                ARREADY_M0 = !sel_m1 && ARREADY_S;
                ARREADY_M1 = sel_m1 && ARREADY_S;
            end
        end
    end

endmodule
